// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants: FIFO entry layout and field offsets.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RX_ENTRY_W = 10;
    localparam int unsigned DATA_LSB   = 0;
    localparam int unsigned PERR_BIT   = 8;
    localparam int unsigned FERR_BIT   = 9;

    // Bit order matches the offsets above: {ferr, perr, data[7:0]}
    typedef struct packed {
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W register array: synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned W      = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO between the UART receiver and the APB registers: pointers, level,
// status flags and sticky overflow around a first-word-fall-through register array.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AFULL_TH = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fifo_write_n,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_parity_err,
    input  logic                wr_framing_err,
    input  logic                read_rx_byte,
    input  logic                clear_overflow,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_parity_err,
    output logic                rx_framing_err,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                rx_afull,
    output logic [ADDR_W:0]     rx_level,
    output logic                rx_overflow
);

    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  empty_c, full_c, pop_c, push_c, drop_c;
    rx_entry_t             wr_entry_c;
    logic [RX_ENTRY_W-1:0] rd_entry_c;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts write+pop.
    always_comb begin
        empty_c    = (level_q == '0);
        full_c     = (level_q == LVL_W'(DEPTH));
        pop_c      = read_rx_byte && !empty_c;
        push_c     = !fifo_write_n && (!full_c || pop_c);
        drop_c     = !fifo_write_n && full_c && !pop_c;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.ferr = wr_framing_err;
        wr_entry_c.perr = wr_parity_err;
        wr_entry_c.data = wr_data;
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (RX_ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (wr_entry_c),
        .raddr (rd_ptr_q),
        .rdata (rd_entry_c)
    );

    // Head entry is shown directly from storage, forced to zero while empty.
    assign rx_data        = empty_c ? '0   : rd_entry_c[DATA_LSB +: DATA_W];
    assign rx_parity_err  = empty_c ? 1'b0 : rd_entry_c[PERR_BIT];
    assign rx_framing_err = empty_c ? 1'b0 : rd_entry_c[FERR_BIT];
    assign rx_empty       = empty_c;
    assign rx_full        = full_c;
    assign rx_afull       = (level_q >= LVL_W'(AFULL_TH));
    assign rx_level       = level_q;
    assign rx_overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl: accepted writes queue expected entries,
// a monitor compares the head on every accepted pop; status is checked against a model.
module tb_uart_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fifo_write_n;
    logic [7:0] wr_data;
    logic       wr_parity_err;
    logic       wr_framing_err;
    logic       read_rx_byte;
    logic       clear_overflow;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_framing_err;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_afull;
    logic [4:0] rx_level;
    logic       rx_overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    int         m_lvl = 0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4), .AFULL_TH(12)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_write_n   (fifo_write_n),
        .wr_data        (wr_data),
        .wr_parity_err  (wr_parity_err),
        .wr_framing_err (wr_framing_err),
        .read_rx_byte   (read_rx_byte),
        .clear_overflow (clear_overflow),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_framing_err (rx_framing_err),
        .rx_empty       (rx_empty),
        .rx_full        (rx_full),
        .rx_afull       (rx_afull),
        .rx_level       (rx_level),
        .rx_overflow    (rx_overflow)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every pop the DUT accepts must present the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && read_rx_byte === 1'b1 && rx_empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                chk("head_entry", int'({rx_framing_err, rx_parity_err, rx_data}),
                    int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_status();
        chk("rx_level",    int'(rx_level),    m_lvl);
        chk("rx_empty",    int'(rx_empty),    int'(m_lvl == 0));
        chk("rx_full",     int'(rx_full),     int'(m_lvl == 16));
        chk("rx_afull",    int'(rx_afull),    int'(m_lvl >= 12));
        chk("rx_overflow", int'(rx_overflow), int'(m_ovf));
        if (m_lvl == 0) begin
            chk("rx_data_empty", int'({rx_framing_err, rx_parity_err, rx_data}), 0);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge level.
    task automatic do_op(input logic wr, input logic [7:0] d, input logic pe,
                         input logic fe, input logic rd, input logic clr);
        logic pop_m, wr_ok;
        fifo_write_n   = ~wr;
        wr_data        = d;
        wr_parity_err  = pe;
        wr_framing_err = fe;
        read_rx_byte   = rd;
        clear_overflow = clr;
        pop_m = rd && (m_lvl > 0);
        wr_ok = wr && ((m_lvl < 16) || pop_m);
        if (wr_ok) exp_q.push_back({fe, pe, d});
        if (wr_ok && !pop_m) m_lvl++;
        else if (!wr_ok && pop_m) m_lvl--;
        if (wr && !wr_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        fifo_write_n   = 1'b1;
        wr_data        = 8'h00;
        wr_parity_err  = 1'b0;
        wr_framing_err = 1'b0;
        read_rx_byte   = 1'b0;
        clear_overflow = 1'b0;
        check_status();
    endtask

    task automatic wr_byte(input logic [7:0] d);
        do_op(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_byte();
        do_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // 1: reset with junk pending on every input
        reset_n        = 1'b0;
        fifo_write_n   = 1'b0;
        wr_data        = 8'hFF;
        wr_parity_err  = 1'b1;
        wr_framing_err = 1'b1;
        read_rx_byte   = 1'b1;
        clear_overflow = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n        = 1'b1;
        fifo_write_n   = 1'b1;
        wr_data        = 8'h00;
        wr_parity_err  = 1'b0;
        wr_framing_err = 1'b0;
        read_rx_byte   = 1'b0;
        clear_overflow = 1'b0;
        chk("reset_empty", int'(rx_empty), 1);
        chk("reset_data",  int'(rx_data), 0);
        check_status();

        // 2: three bytes in order
        wr_byte(8'h41);
        chk("fwft_head", int'(rx_data), 'h41);
        wr_byte(8'h42);
        wr_byte(8'h43);
        repeat (3) pop_byte();
        chk("empty_after_3", int'(rx_empty), 1);
        pop_byte();

        // 3: fill past full, overflow, set-wins, drain, clear
        for (int i = 0; i < 17; i++) wr_byte(8'(i));
        chk("full_level", int'(rx_level), 16);
        chk("ovf_set", int'(rx_overflow), 1);
        do_op(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", int'(rx_overflow), 1);
        repeat (16) pop_byte();
        do_op(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", int'(rx_overflow), 0);

        // 4: write+pop while full
        for (int i = 0; i < 16; i++) wr_byte(8'h20 + 8'(i));
        do_op(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_wp_level", int'(rx_level), 16);
        chk("full_wp_ovf", int'(rx_overflow), 0);
        repeat (15) pop_byte();
        chk("last_is_a5", int'(rx_data), 'hA5);
        pop_byte();

        // 4b: write+pop while empty keeps the write
        do_op(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_wp_level", int'(rx_level), 1);
        pop_byte();

        // 5: parity and framing status travel with their bytes
        do_op(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("head_perr", int'(rx_parity_err), 1);
        chk("head_ferr0", int'(rx_framing_err), 0);
        pop_byte();
        chk("head_ferr", int'(rx_framing_err), 1);
        chk("head_66", int'(rx_data), 'h66);
        pop_byte();

        // 6: interleaved traffic across pointer wrap, then reset at level 12
        for (int i = 0; i < 8; i++) wr_byte(8'h80 + 8'(i));
        for (int i = 0; i < 40; i++) do_op(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) wr_byte(8'h10 + 8'(i));
        chk("afull_11", int'(rx_afull), 0);
        wr_byte(8'h13);
        chk("afull_12", int'(rx_afull), 1);
        chk("level_12", int'(rx_level), 12);
        reset_n      = 1'b0;
        fifo_write_n = 1'b0;
        read_rx_byte = 1'b1;
        wr_data      = 8'h99;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_lvl = 0;
        m_ovf = 1'b0;
        check_status();
        reset_n      = 1'b1;
        fifo_write_n = 1'b1;
        read_rx_byte = 1'b0;
        wr_data      = 8'h00;
        @(posedge clk);
        #1;
        check_status();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
